// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: IEEE-754 single add/sub, round-nearest-even, subnormals flushed; flags port only with FPU_FLAGS_EN.
// Fixed 4-cycle start->done latency, one op in flight; start is ignored while busy (no queueing).
module fp_addsub_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
`ifdef FPU_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ALIGN = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;

  logic [2:0] state;

  // unpack at the input ports; exponent 0 is treated as a signed zero
  logic        a_nan, a_inf, b_nan, b_inf, b_sgn;
  logic [23:0] a_man, b_man;
  logic        sp_nxt;
  logic [31:0] sp_res_nxt;

  always_comb begin
    b_sgn = b[31] ^ op;
    a_nan = (&a[30:23]) & (|a[22:0]);
    a_inf = (&a[30:23]) & ~(|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    b_inf = (&b[30:23]) & ~(|b[22:0]);
    a_man = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    b_man = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    sp_nxt     = 1'b1;
    sp_res_nxt = 32'h7FC0_0000;
    if (a_nan | b_nan)                      sp_res_nxt = 32'h7FC0_0000;
    else if (a_inf & b_inf & (a[31] != b_sgn)) sp_res_nxt = 32'h7FC0_0000;
    else if (a_inf)                         sp_res_nxt = {a[31], 8'hFF, 23'd0};
    else if (b_inf)                         sp_res_nxt = {b_sgn, 8'hFF, 23'd0};
    else                                    sp_nxt = 1'b0;
  end

  // latched operands
  logic        s_a, s_b, sp;
  logic [7:0]  e_a, e_b;
  logic [23:0] m_a, m_b;
  logic [31:0] sp_res;
`ifdef FPU_FLAGS_EN
  logic        sp_inv;
`endif

  // ALIGN: larger magnitude first, smaller shifted into {1, frac, g, r, s}
  logic        a_ge, l_s;
  logic [7:0]  l_e, s_e, d;
  logic [23:0] l_m, s_m;
  logic [26:0] fld, sh;

  always_comb begin
    a_ge = {e_a, m_a} >= {e_b, m_b};
    l_s  = a_ge ? s_a : s_b;
    l_e  = a_ge ? e_a : e_b;
    l_m  = a_ge ? m_a : m_b;
    s_e  = a_ge ? e_b : e_a;
    s_m  = a_ge ? m_b : m_a;
    d    = l_e - s_e;
    fld  = {s_m, 3'b000};
    if (d >= 8'd27) begin
      sh = {26'd0, |s_m};
    end else begin
      sh    = fld >> d[4:0];
      sh[0] = sh[0] | (|(fld & ((27'd1 << d[4:0]) - 27'd1)));
    end
  end

  logic        r_sgn, r_sub;
  logic [7:0]  r_exp;
  logic [26:0] r_ml, r_sm;
  logic [27:0] r_sum;

  // NORM: single-cycle leading-zero count over the non-carry field
  logic [4:0]  lz;
  logic        lz_found;

  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && r_sum[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
  end

  logic        n_sgn, n_zero;
  logic [26:0] n_man;
  logic signed [9:0] n_exp;

  // ROUND: nearest-even on {g, r, s}, then overflow / flush / special override
  logic        inc;
  logic [24:0] m25;
  logic signed [9:0] re;
  logic [22:0] frac;
  logic [31:0] rnd_res;
`ifdef FPU_FLAGS_EN
  logic [3:0]  rnd_flags;
`endif

  always_comb begin
    inc     = n_man[2] & (n_man[1] | n_man[0] | n_man[3]);
    m25     = {1'b0, n_man[26:3]} + {24'd0, inc};
    re      = m25[24] ? (n_exp + 10'sd1) : n_exp;
    frac    = m25[24] ? m25[23:1] : m25[22:0];
    rnd_res = {n_sgn, re[7:0], frac};
`ifdef FPU_FLAGS_EN
    rnd_flags = {3'b000, |n_man[2:0]};
`endif
    if (sp) begin
      rnd_res = sp_res;
`ifdef FPU_FLAGS_EN
      rnd_flags = {sp_inv, 3'b000};
`endif
    end else if (n_zero) begin
      rnd_res = {n_sgn, 31'd0};
`ifdef FPU_FLAGS_EN
      rnd_flags = 4'b0000;
`endif
    end else if (n_exp <= 10'sd0) begin
      rnd_res = {n_sgn, 31'd0};
`ifdef FPU_FLAGS_EN
      rnd_flags = 4'b0011;
`endif
    end else if (re >= 10'sd255) begin
      rnd_res = {n_sgn, 8'hFF, 23'd0};
`ifdef FPU_FLAGS_EN
      rnd_flags = 4'b0101;
`endif
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 32'd0;
      s_a    <= 1'b0;
      s_b    <= 1'b0;
      sp     <= 1'b0;
      e_a    <= 8'd0;
      e_b    <= 8'd0;
      m_a    <= 24'd0;
      m_b    <= 24'd0;
      sp_res <= 32'd0;
      r_sgn  <= 1'b0;
      r_sub  <= 1'b0;
      r_exp  <= 8'd0;
      r_ml   <= 27'd0;
      r_sm   <= 27'd0;
      r_sum  <= 28'd0;
      n_sgn  <= 1'b0;
      n_zero <= 1'b0;
      n_man  <= 27'd0;
      n_exp  <= 10'sd0;
`ifdef FPU_FLAGS_EN
      sp_inv <= 1'b0;
      flags  <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ALIGN;
            s_a    <= a[31];
            s_b    <= b_sgn;
            e_a    <= a[30:23];
            e_b    <= b[30:23];
            m_a    <= a_man;
            m_b    <= b_man;
            sp     <= sp_nxt;
            sp_res <= sp_res_nxt;
`ifdef FPU_FLAGS_EN
            sp_inv <= a_inf & b_inf & (a[31] != b_sgn);
            flags  <= 4'd0;
`endif
          end
        end
        ALIGN: begin
          state <= ADD;
          r_sgn <= l_s;
          r_sub <= (s_a != s_b);
          r_exp <= l_e;
          r_ml  <= {l_m, 3'b000};
          r_sm  <= sh;
        end
        ADD: begin
          state <= NORM;
          r_sum <= r_sub ? ({1'b0, r_ml} - {1'b0, r_sm}) : ({1'b0, r_ml} + {1'b0, r_sm});
        end
        NORM: begin
          state  <= ROUND;
          n_zero <= (r_sum == 28'd0);
          // exact zero from an effective subtraction is +0; like-signed zeros keep their sign
          n_sgn  <= (r_sum == 28'd0) ? (r_sgn & ~r_sub) : r_sgn;
          if (r_sum[27]) begin
            n_man <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            n_exp <= $signed({2'b00, r_exp}) + 10'sd1;
          end else begin
            n_man <= r_sum[26:0] << lz;
            n_exp <= $signed({2'b00, r_exp}) - $signed({5'd0, lz});
          end
        end
        ROUND: begin
          state  <= IDLE;
          done   <= 1'b1;
          result <= rnd_res;
`ifdef FPU_FLAGS_EN
          flags  <= rnd_flags;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Multi-cycle IEEE-754 single-precision adder/subtractor for the MIPS FPU datapath. It sits between the FP register file read ports and the FP write-back mux. The CPU control issues `add.s` / `sub.s` through a start/done handshake and writes `result` to the FP register file when `done` pulses. Fixed latency, one operation in flight, round-to-nearest-even, subnormals flushed to zero.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: operation request, sampled only in IDLE.
- `op` in 1: 0 = a+b, 1 = a−b. Sampled with `start`.
- `a` in 32: operand A, IEEE-754 single. Sampled with `start`.
- `b` in 32: operand B, IEEE-754 single. Sampled with `start`.
- `busy` out 1: high while an operation is in flight (state ≠ IDLE).
- `done` out 1: one-cycle completion pulse.
- `result` out 32: sum or difference. Held until the next completion.
- `flags` out 4: {invalid, overflow, underflow, inexact}. Present only with `FPU_FLAGS_EN`.

## Operation
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. Every transition is unconditional except IDLE→ALIGN, which requires `start`.
- Accept (IDLE & `start`):
  - Latch a, b, op. The effective sign of b is `b[31]^op`.
  - Unpack with hidden bit. Exponent 0 (zero or subnormal) is treated as ±0.
- ALIGN:
  - Swap so the operand with the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference into a 27-bit field {1, 23 frac, guard, round, sticky}.
  - Sticky ORs all bits shifted past the field. A difference ≥ 26 leaves only sticky.
- ADD: add mantissas if the signs match, otherwise subtract (larger − smaller). Result is 28 bits including carry.
- NORM:
  - On carry-out, shift right 1 (OR the lost bit into sticky) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count (single-cycle LZC) and decrement the exponent.
  - An all-zero mantissa gives exact zero.
- ROUND:
  - Round to nearest even: increment if G & (R | S | LSB).
  - If rounding carries out, renormalize and increment the exponent.
  - Pack the result, register it, and pulse `done`.
- Special cases (resolved at accept, result forced in ROUND):
  - Any NaN input → 0x7FC00000 (canonical qNaN).
  - ∞ − ∞ (effective) → 0x7FC00000, invalid = 1.
  - ∞ ± finite → the ∞ with its effective sign.
  - Exponent ≥ 255 after rounding → ±∞ (0x7F800000 | sign), overflow = 1, inexact = 1.
  - Exponent ≤ 0 after normalization → ±0 (flush), underflow = 1, inexact = 1.
- Zero sign:
  - Exact-zero result from x − x is +0.
  - (−0) + (−0) = −0.
  - (+0) + (−0) = +0.

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE, `busy` = 0, `done` = 0, `result` = 0x00000000, `flags` = 0.
- Reset mid-operation aborts the operation with no `done`. Latched operands are discarded.
- Operation timeline for `start` sampled high at edge N:
  - `busy` is high from edge N through edge N+4.
  - `done` and `result` update at edge N+4. `done` is high for exactly one cycle.
  - Latency is 4 cycles and does not depend on the data.
- `start` while `busy` is ignored. No queueing, no error.
- `start` high during the `done` cycle (state IDLE) is accepted. Peak throughput is one operation per 5 cycles.
- Inputs a/b/op may change freely after the accept edge.
- `result` and `flags` hold their value between completions.

## Configuration
- `FPU_FLAGS_EN` defined:
  - The `flags` port exists.
  - Flags are registered with `result` at completion and cleared at the next accept.
  - inexact = G | R | S before rounding, plus the overflow and underflow cases.
- Not defined:
  - No `flags` port and no flag logic.
  - `result`, `done`, `busy` and timing are identical to the `FPU_FLAGS_EN` build.

## Test plan
- Reset, then 0x3FC00000 + 0x40100000 (1.5 + 2.25), op = 0 → `done` at start+4, `result` = 0x40700000. Check `busy` cycle by cycle.
- op = 1, 0x40200000 − 0x3F800000 (2.5 − 1.0) → 0x3FC00000. Then 0x3F800000 − 0x3F800000 → 0x00000000 (+0). Issue back-to-back with `start` held high during `done`.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags = 4'b0101. Then 0x7F800000 − 0x7F800000 → 0x7FC00000, flags = 4'b1000.
- 0x3F800000 + 0x33800000 (1 + 2⁻²⁴, tie) → 0x3F800000, inexact = 1. Then 0x3F800001 + 0x33800000 → 0x3F800002 (round to even).
- Pulse `start` while `busy` with different operands → ignored, first result unchanged. Assert `reset_n` = 0 at start+2 → no `done`, `result` = 0, FSM back in IDLE.
- 0x00400000 (subnormal) + 0x3F800000 → 0x3F800000. Then 0x00800000 − 0x00800001 → 0x80000000, underflow = 1.
